// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with a synchronous-read ROM,
// an IF/ID holding register, stall/redirect handling and a sticky halt.
// Optional macro FETCH_DYN_COUNT_EN enables the 32-bit delivered-instruction
// counter on dyn_count; when undefined dyn_count is tied to zero.
module fetch_stage #(
    parameter int unsigned          PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt_in,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_en,
    input  logic [8:0]          imem_data,
    output logic [8:0]          instr_out,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                halted,
    output logic [31:0]         dyn_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] pend_addr;
    logic                pending;
    logic                halt_req;

    // Halt when decode asks, or when a halt opcode is being handed over
    assign halt_req = halt_in ||
                      (instr_valid && !stall && (instr_out[8:4] == 5'b11010));

    assign halted = (state == HALTED);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and ROM interface
    always_comb begin
        state_next = state;
        imem_en    = 1'b0;
        imem_addr  = fetch_pc;
        case (state)
            RUN: begin
                imem_en = 1'b1;
                // While stalled with a read outstanding, re-present that
                // read's address so the ROM output still holds its data
                // when the stall lifts; fetch_pc itself stays put.
                if (stall && pending) begin
                    imem_addr = pend_addr;
                end
                if (halt_req) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Fetch PC, outstanding-read tracking and IF/ID register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            pend_addr   <= '0;
            pending     <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else if (state == RUN) begin
            if (halt_req) begin
                instr_valid <= 1'b0;
                pending     <= 1'b0;
            end else if (redirect_valid) begin
                fetch_pc    <= redirect_pc;
                pending     <= 1'b0;
                instr_valid <= 1'b0;
            end else if (!stall) begin
                instr_out   <= imem_data;
                pc_out      <= pend_addr;
                instr_valid <= pending;
                pend_addr   <= fetch_pc;
                pending     <= 1'b1;
                fetch_pc    <= fetch_pc + PC_WIDTH'(1);
            end
        end
    end

`ifdef FETCH_DYN_COUNT_EN
    logic [31:0] count;

    // Count every instruction accepted by decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (instr_valid && !stall) begin
            count <= count + 32'd1;
        end
    end

    assign dyn_count = count;
`else
    assign dyn_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a synchronous ROM model
// (mem[i] = i). A second instance with PC_WIDTH=4 exercises PC wrap-around.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FETCH_DYN_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Main instance, PC_WIDTH = 10
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        halt_in;
    logic [9:0]  imem_addr;
    logic        imem_en;
    logic [8:0]  imem_data;
    logic [8:0]  instr_out;
    logic        instr_valid;
    logic [9:0]  pc_out;
    logic        halted;
    logic [31:0] dyn_count;

    // Wrap instance, PC_WIDTH = 4
    logic        rst_w_n;
    logic        stall_w;
    logic        redirect_valid_w;
    logic [3:0]  redirect_pc_w;
    logic        halt_in_w;
    logic [3:0]  imem_addr_w;
    logic        imem_en_w;
    logic [8:0]  imem_data_w;
    logic [8:0]  instr_out_w;
    logic        instr_valid_w;
    logic [3:0]  pc_out_w;
    logic        halted_w;
    logic [31:0] dyn_count_w;

    logic [8:0] rom   [1024];
    logic [8:0] rom_w [16];

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.PC_WIDTH(10), .RESET_PC(10'd0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_in(halt_in), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .instr_out(instr_out),
        .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted),
        .dyn_count(dyn_count)
    );

    fetch_stage #(.PC_WIDTH(4), .RESET_PC(4'd0)) dut_w (
        .clk(clk), .rst_n(rst_w_n), .stall(stall_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .halt_in(halt_in_w), .imem_addr(imem_addr_w), .imem_en(imem_en_w),
        .imem_data(imem_data_w), .instr_out(instr_out_w),
        .instr_valid(instr_valid_w), .pc_out(pc_out_w), .halted(halted_w),
        .dyn_count(dyn_count_w)
    );

    // Synchronous ROMs: data appears after the edge that sampled addr/en
    always @(posedge clk) begin
        if (imem_en) imem_data <= rom[imem_addr];
        if (imem_en_w) imem_data_w <= rom_w[imem_addr_w];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i);
        for (int i = 0; i < 16; i++) rom_w[i] = 9'(i);
        imem_data        = '0;
        imem_data_w      = '0;
        rst_n            = 1'b0;
        stall            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        halt_in          = 1'b0;
        rst_w_n          = 1'b0;
        stall_w          = 1'b0;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = '0;
        halt_in_w        = 1'b0;

        // Reset state
        step(2);
        chk("rst_valid",  32'(instr_valid), 32'd0);
        chk("rst_pc_out", 32'(pc_out),      32'd0);
        chk("rst_instr",  32'(instr_out),   32'd0);
        chk("rst_halted", 32'(halted),      32'd0);
        chk("rst_count",  dyn_count,        32'd0);
        chk("rst_en",     32'(imem_en),     32'd1);
        chk("rst_addr",   32'(imem_addr),   32'd0);

        // First fetch: valid two edges after release
        rst_n = 1'b1;
        step(1);
        chk("e1_valid", 32'(instr_valid), 32'd0);
        chk("e1_addr",  32'(imem_addr),   32'd1);
        step(1);
        chk("e2_valid", 32'(instr_valid), 32'd1);
        chk("e2_pc",    32'(pc_out),      32'd0);
        chk("e2_instr", 32'(instr_out),   32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk("seq_pc",    32'(pc_out),      32'(k));
            chk("seq_valid", 32'(instr_valid), 32'd1);
        end
        step(2);
        chk("pre_stall_pc", 32'(pc_out), 32'd5);

        // Stall for three edges while holding pc 5
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("stall_pc",    32'(pc_out),      32'd5);
            chk("stall_instr", 32'(instr_out),   32'd5);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        step(1);
        chk("post_stall_pc",    32'(pc_out),    32'd6);
        chk("post_stall_instr", 32'(instr_out), 32'd6);

        // Redirect to 0x40 while stalled
        redirect_valid = 1'b1;
        redirect_pc    = 10'h040;
        stall          = 1'b1;
        step(1);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_addr",  32'(imem_addr),   32'h40);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step(1);
        chk("redir_e1_valid", 32'(instr_valid), 32'd0);
        step(1);
        chk("redir_e2_valid", 32'(instr_valid), 32'd1);
        chk("redir_e2_pc",    32'(pc_out),      32'h40);
        chk("redir_e2_instr", 32'(instr_out),   32'h40);
        chk("count_after_redir", dyn_count, CNT_EN ? 32'd6 : 32'd0);

        // Halt opcode delivered at pc 7
        rom[7] = 9'h1A0;
        rst_n  = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(9);
        chk("halt_op_pc",    32'(pc_out),    32'd7);
        chk("halt_op_instr", 32'(instr_out), 32'h1A0);
        step(1);
        chk("halted",        32'(halted),      32'd1);
        chk("halted_en",     32'(imem_en),     32'd0);
        chk("halted_valid",  32'(instr_valid), 32'd0);
        chk("halted_pc",     32'(pc_out),      32'd7);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h040;
        stall          = 1'b1;
        step(1);
        chk("halted_redir_halted", 32'(halted),    32'd1);
        chk("halted_redir_addr",   32'(imem_addr), 32'd9);
        chk("halted_redir_pc",     32'(pc_out),    32'd7);

        // Reset recovers from HALTED despite stall and redirect
        rst_n = 1'b0;
        step(1);
        chk("recover_halted", 32'(halted),      32'd0);
        chk("recover_valid",  32'(instr_valid), 32'd0);
        chk("recover_en",     32'(imem_en),     32'd1);
        chk("recover_addr",   32'(imem_addr),   32'd0);
        chk("recover_count",  dyn_count,        32'd0);
        rom[7]         = 9'd7;
        redirect_valid = 1'b0;
        stall          = 1'b0;

        // halt_in wins over a simultaneous redirect
        rst_n = 1'b1;
        step(3);
        chk("prio_pre_pc", 32'(pc_out), 32'd1);
        halt_in        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 10'h040;
        step(1);
        chk("prio_halted", 32'(halted),    32'd1);
        chk("prio_addr",   32'(imem_addr), 32'd3);
        halt_in        = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        step(1);

        // PC wrap with PC_WIDTH = 4
        rst_w_n = 1'b1;
        step(17);
        chk("wrap_pc15",    32'(pc_out_w),      32'd15);
        chk("wrap_valid15", 32'(instr_valid_w), 32'd1);
        step(1);
        chk("wrap_pc0",    32'(pc_out_w),    32'd0);
        chk("wrap_instr0", 32'(instr_out_w), 32'd0);
        step(1);
        chk("wrap_pc1",   32'(pc_out_w), 32'd1);
        chk("wrap_count", dyn_count_w,   CNT_EN ? 32'd17 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
